cmos_driver_sequencer: RTL and testbench
========================================

# cmos_driver_sequencer

Break-before-make sequencer for a complementary pull-up/pull-down switch pair: a PMOS to supply1 and an NMOS to supply0 sharing one output node. It accepts drive commands (high, low, high-Z) over a valid/ready handshake and generates the two gate controls. Between opposite drive states it inserts a programmable dead time, so both switches are never on together and shoot-through cannot occur. It sits between digital control logic and the switch-level pad/driver cells.

## Interface
- DEAD_W, 4, width of the dead-time count input
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command this cycle
- cmd  input  2  2'b00 HIZ, 2'b01 DRIVE_LOW, 2'b10 DRIVE_HIGH, 2'b11 reserved (treated as HIZ)
- dead_time  input  DEAD_W  dead-time length, sampled on command accept
- kill  input  1  emergency release of both switches, highest priority
- pgate  output  1  PMOS gate, active-low (0 = pull-up on)
- ngate  output  1  NMOS gate, active-high (1 = pull-down on)
- busy  output  1  high while in DEAD

## Operation
- All outputs are registered. The FSM has four states: OFF (pgate=1, ngate=0), UP (pgate=0, ngate=0), DN (pgate=1, ngate=1), DEAD (pgate=1, ngate=0).
- Invariant, at all times including reset: pgate=0 and ngate=1 never occur together.
- Accept occurs when cmd_valid & cmd_ready at a rising edge. cmd_ready = 1 in OFF, UP and DN; cmd_ready = 0 in DEAD.
- Transitions on accept:
  - OFF→UP or OFF→DN: direct, no dead time.
  - UP/DN→OFF: direct.
  - Same-state command: no change, no glitch on the gates.
  - UP→DN or DN→UP: enter DEAD, load counter = dead_time, latch the target.
- DEAD:
  - The counter decrements each cycle.
  - When the counter is 0, the next state is the latched target.
  - DEAD therefore lasts exactly dead_time+1 cycles. dead_time=0 still gives 1 dead cycle.
- kill=1: next state is OFF from any state. The counter and target are cleared. A command presented in the same cycle is not accepted, because cmd_ready is forced to 0 while kill=1.
- Reserved cmd 2'b11 is accepted and behaves as HIZ.
- dead_time changes while in DEAD have no effect.

## Timing
- Reset values: pgate=1, ngate=0, cmd_ready=1, busy=0, state OFF, counter 0.
- Reset asserted during DEAD, UP or DN: OFF after the next edge. A latched target is discarded.
- Command accepted at edge N with a direct transition: new gate values are visible after edge N (1-cycle latency).
- Opposite transition accepted at edge N:
  - Both switches off after N.
  - busy=1 for cycles N+1 … N+dead_time+1.
  - Target gates are visible after edge N+dead_time+1.
  - cmd_ready returns to 1 in the same cycle as the target gates.
- A command held valid during DEAD is accepted in the first cycle cmd_ready=1. It is evaluated against the new state.

## Structure
- Package cmos_drv_pkg holds:
  - the state enum (OFF, UP, DN, DEAD);
  - cmd localparams CMD_HIZ, CMD_LOW, CMD_HIGH;
  - the safe idle gate constants PGATE_OFF=1, NGATE_OFF=0.
- Sub-module dead_time_counter(clk, reset, load, load_val[DEAD_W], clear, zero): a loadable down-counter with a zero flag.
- The top level contains the FSM, target register and output registers only.

## Test plan
- Reset, then cmd=DRIVE_HIGH: pgate=0, ngate=0 one cycle after accept, busy stays 0.
- UP state, cmd=DRIVE_LOW with dead_time=3: both gates off for 4 cycles, busy=1 for 4 cycles, cmd_ready=0 throughout, then pgate=1 and ngate=1.
- DN state, cmd=DRIVE_HIGH with dead_time=0: exactly 1 dead cycle, then UP.
- kill asserted on the 2nd DEAD cycle of a DN→UP transition with dead_time=5, plus a simultaneous valid cmd: OFF next cycle, no UP ever driven, cmd not accepted while kill=1.
- Reset asserted mid-DEAD: OFF with reset values. Reserved cmd 2'b11 from UP: OFF with no dead time.
- Random commands, dead_time and kill over 10k cycles:
  - assertion that pgate=0 and ngate=1 never coincide;
  - every opposite transition shows exactly dead_time+1 off cycles.

Source files
------------

// File: rtl/cmos_driver_sequencer_pkg.sv
// Shared types and constants for the break-before-make gate sequencer.
//   state_t       : sequencer FSM states (OFF, UP, DN, DEAD)
//   CMD_*         : drive command encodings (2'b11 is reserved and decodes as HIZ)
//   PGATE/NGATE_OFF : safe gate levels with both switches released
//   cmd_to_state  : maps a drive command onto the steady state it requests
package cmos_drv_pkg;

   typedef enum logic [1:0] {
      StOff  = 2'd0,
      StUp   = 2'd1,
      StDn   = 2'd2,
      StDead = 2'd3
   } state_t;

   localparam logic [1:0] CMD_HIZ  = 2'b00;
   localparam logic [1:0] CMD_LOW  = 2'b01;
   localparam logic [1:0] CMD_HIGH = 2'b10;

   localparam logic PGATE_OFF = 1'b1;
   localparam logic NGATE_OFF = 1'b0;

   // Anything other than LOW/HIGH (including the reserved code) releases the node.
   function automatic state_t cmd_to_state(logic [1:0] c);
      state_t s;
      case (c)
         CMD_LOW:  s = StDn;
         CMD_HIGH: s = StUp;
         default:  s = StOff;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/cmos_driver_sequencer_if.sv
// Command channel of the gate sequencer.
//   cmd_valid : command present
//   cmd_ready : sequencer can accept a command this cycle
//   cmd       : drive command (HIZ / LOW / HIGH / reserved)
//   dead_time : dead-time length, sampled on accept
// master drives commands, slave is the sequencer.
interface cmos_driver_sequencer_if #(
   parameter int unsigned DEAD_W = 4
) ();

   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd;
   logic [DEAD_W-1:0] dead_time;

   modport master (
      output cmd_valid,
      output cmd,
      output dead_time,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd,
      input  dead_time,
      output cmd_ready
   );

endinterface

// File: rtl/cmos_driver_sequencer_counter.sv
// Loadable down-counter timing the dead interval.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   load       : load load_val (clear has priority)
//   load_val   : value to load
//   clear      : force count to zero
//   zero       : count is zero
// Counts down by one per cycle while nonzero; it rests at zero otherwise.
module dead_time_counter #(
   parameter int unsigned DEAD_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [DEAD_W-1:0] load_val,
   input  logic              clear,
   output logic              zero
);

   logic [DEAD_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (load) begin
         count_d = load_val;
      end else if (count_q != '0) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/cmos_driver_sequencer.sv
// Break-before-make sequencer for a complementary PMOS/NMOS output pair.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   cmd_bus    : command channel (slave side)
//   kill       : emergency release of both switches, highest priority
//   pgate      : PMOS gate, active-low
//   ngate      : NMOS gate, active-high
//   busy       : high while the dead interval is running
// Opposite drive changes pass through DEAD for dead_time+1 cycles so the
// pull-up and pull-down are never on together.
module cmos_driver_sequencer
   import cmos_drv_pkg::*;
#(
   parameter int unsigned DEAD_W = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   cmos_driver_sequencer_if.slave  cmd_bus,
   input  logic                    kill,
   output logic                    pgate,
   output logic                    ngate,
   output logic                    busy
);

   state_t state_q, state_d;
   state_t target_q, target_d;
   state_t want;
   logic   accept;
   logic   cnt_load, cnt_clear, cnt_zero;
   logic   pgate_q, ngate_q, busy_q, ready_q;

   dead_time_counter #(
      .DEAD_W (DEAD_W)
   ) u_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cmd_bus.dead_time),
      .clear    (cnt_clear),
      .zero     (cnt_zero)
   );

   // kill blocks acceptance in the same cycle it is seen.
   assign cmd_bus.cmd_ready = ready_q & ~kill;
   assign accept            = cmd_bus.cmd_valid & cmd_bus.cmd_ready;

   always_comb begin
      state_d   = state_q;
      target_d  = target_q;
      cnt_load  = 1'b0;
      cnt_clear = 1'b0;
      want      = cmd_to_state(cmd_bus.cmd);

      unique case (state_q)
         StOff, StUp, StDn: begin
            if (accept) begin
               if ((state_q == StUp && want == StDn) || (state_q == StDn && want == StUp)) begin
                  state_d  = StDead;
                  target_d = want;
                  cnt_load = 1'b1;
               end else begin
                  state_d = want;
               end
            end
         end
         StDead: begin
            if (cnt_zero) begin
               state_d  = target_q;
               target_d = StOff;
            end
         end
         default: state_d = StOff;
      endcase

      if (kill) begin
         state_d   = StOff;
         target_d  = StOff;
         cnt_clear = 1'b1;
      end
   end

   // Gates come straight from the registered next state, so a same-state
   // command rewrites identical values and cannot glitch.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StOff;
         target_q <= StOff;
         pgate_q  <= PGATE_OFF;
         ngate_q  <= NGATE_OFF;
         busy_q   <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         pgate_q  <= (state_d == StUp) ? 1'b0 : PGATE_OFF;
         ngate_q  <= (state_d == StDn) ? 1'b1 : NGATE_OFF;
         busy_q   <= (state_d == StDead);
         ready_q  <= (state_d != StDead);
      end
   end

   assign pgate = pgate_q;
   assign ngate = ngate_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_cmos_driver_sequencer.sv
module tb_cmos_driver_sequencer;

   logic clk = 1'b0;
   logic reset;
   logic kill;
   logic pgate, ngate, busy;

   cmos_driver_sequencer_if #(.DEAD_W(4)) cbus ();

   cmos_driver_sequencer #(
      .DEAD_W (4)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .cmd_bus (cbus),
      .kill    (kill),
      .pgate   (pgate),
      .ngate   (ngate),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference: drive level (0 released, 1 low, 2 high) plus remaining dead cycles.
   int m_cur = 0;
   int m_tgt = 0;
   int m_dead_left = 0;
   int run_exp = 0;
   int run_len = 0;
   bit run_abort = 1'b0;

   function automatic int decode(logic [1:0] c);
      if (c == 2'b01) return 1;
      if (c == 2'b10) return 2;
      return 0;
   endfunction

   task automatic chk(string name, logic obs, logic exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", name, obs, exp);
      end
   endtask

   task automatic model_edge();
      int w;
      if (reset || kill) begin
         if (m_dead_left > 0) run_abort = 1'b1;
         m_cur = 0;
         m_dead_left = 0;
      end else if (m_dead_left > 0) begin
         m_dead_left--;
         if (m_dead_left == 0) m_cur = m_tgt;
      end else if (cbus.cmd_valid) begin
         w = decode(cbus.cmd);
         if (m_cur != 0 && w != 0 && w != m_cur) begin
            m_dead_left = int'(cbus.dead_time) + 1;
            m_tgt = w;
            run_exp = m_dead_left;
            run_abort = 1'b0;
         end else begin
            m_cur = w;
         end
      end
   endtask

   task automatic check_outputs(string tag);
      logic ep, en, eb, er;
      ep = !(m_dead_left == 0 && m_cur == 2);
      en = (m_dead_left == 0 && m_cur == 1);
      eb = (m_dead_left > 0);
      er = (m_dead_left == 0) && !kill;
      chk({tag, ".pgate"}, pgate, ep);
      chk({tag, ".ngate"}, ngate, en);
      chk({tag, ".busy"}, busy, eb);
      chk({tag, ".cmd_ready"}, cbus.cmd_ready, er);
      tests++;
      assert (!(pgate === 1'b0 && ngate === 1'b1))
      else begin
         fails++;
         $error("FAIL %s.shoot_through observed=pgate%b/ngate%b expected=not 0/1", tag, pgate,
                ngate);
      end
      if (busy === 1'b1) begin
         run_len++;
      end else if (run_len > 0) begin
         if (!run_abort) begin
            tests++;
            assert (run_len == run_exp)
            else begin
               fails++;
               $error("FAIL %s.dead_len observed=%0d expected=%0d", tag, run_len, run_exp);
            end
         end
         run_len = 0;
      end
   endtask

   task automatic cycle(string tag);
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check_outputs(tag);
   endtask

   task automatic send(logic [1:0] c, logic [3:0] dt);
      cbus.cmd_valid = 1'b1;
      cbus.cmd = c;
      cbus.dead_time = dt;
   endtask

   initial begin
      reset = 1'b1;
      kill = 1'b0;
      cbus.cmd_valid = 1'b0;
      cbus.cmd = 2'b00;
      cbus.dead_time = '0;
      cycle("reset");
      cycle("reset");
      chk("reset_pgate", pgate, 1'b1);
      chk("reset_ready", cbus.cmd_ready, 1'b1);
      reset = 1'b0;
      cycle("idle");

      // OFF -> UP, direct
      send(2'b10, 4'd0);
      cycle("up_accept");
      chk("up_pgate_on", pgate, 1'b0);
      chk("up_no_busy", busy, 1'b0);
      cbus.cmd_valid = 1'b0;
      cycle("up_hold");

      // UP -> DN with dead_time=3; dead_time change during DEAD must be ignored
      send(2'b01, 4'd3);
      cycle("up_dn_accept");
      cbus.cmd_valid = 1'b0;
      cbus.dead_time = 4'd9;
      repeat (5) cycle("up_dn_dead");
      chk("dn_ngate_on", ngate, 1'b1);

      // DN -> UP with dead_time=0: one dead cycle
      send(2'b10, 4'd0);
      cycle("dn_up_accept");
      chk("dn_up_one_dead", busy, 1'b1);
      cbus.cmd_valid = 1'b0;
      cycle("dn_up_done");
      chk("dn_up_pgate_on", pgate, 1'b0);

      // Back to DN, then DN -> UP with dead_time=5 killed on 2nd dead cycle
      send(2'b01, 4'd0);
      cycle("to_dn");
      cbus.cmd_valid = 1'b0;
      repeat (2) cycle("to_dn_wait");
      send(2'b10, 4'd5);
      cycle("kill_dead1");
      cycle("kill_dead2");
      kill = 1'b1;
      #1;
      chk("kill_blocks_ready", cbus.cmd_ready, 1'b0);
      cycle("kill_edge");
      chk("kill_off_pgate", pgate, 1'b1);
      kill = 1'b0;
      cbus.cmd_valid = 1'b0;
      repeat (8) cycle("kill_after");

      // Reset in the middle of DEAD
      send(2'b10, 4'd0);
      cycle("rst_up");
      send(2'b01, 4'd7);
      cycle("rst_dead1");
      cbus.cmd_valid = 1'b0;
      cycle("rst_dead2");
      reset = 1'b1;
      cycle("rst_mid_dead");
      reset = 1'b0;
      repeat (9) cycle("rst_after");
      chk("rst_after_busy", busy, 1'b0);

      // Reserved command from UP releases with no dead time
      send(2'b10, 4'd4);
      cycle("rsv_up");
      send(2'b11, 4'd4);
      cycle("rsv_off");
      chk("rsv_pgate_off", pgate, 1'b1);
      chk("rsv_no_busy", busy, 1'b0);
      cbus.cmd_valid = 1'b0;
      cycle("rsv_idle");

      // Randomized commands, dead_time, kill and occasional reset
      for (int i = 0; i < 10000; i++) begin
         reset = ($urandom_range(299) == 0);
         kill = ($urandom_range(59) == 0);
         cbus.cmd_valid = $urandom_range(1);
         cbus.cmd = 2'($urandom_range(3));
         cbus.dead_time = ($urandom_range(1) == 1) ? 4'($urandom_range(3)) :
                          4'($urandom_range(15));
         cycle("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
